// File: rtl/fetch_pkg.sv
// Shared constants for the instruction-fetch stage.
// State encodings, fetch exception codes and the default boot address.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  localparam logic [7:0]  EXC_NONE           = 8'h00;
  localparam logic [7:0]  EXC_FETCH_MISALIGN = 8'h82;
  localparam logic [31:0] DEF_RESET_PC       = 32'h0000_0000;
  localparam logic [31:0] DEF_PC_STEP        = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the fetch PC, drives the 1-cycle imem.
// Optional FETCH_ALIGN_CHECK_EN flags misaligned redirect targets.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] PC_STEP  = DEF_PC_STEP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        halt,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_addr,
  output logic        mem_ren,
  output logic [31:0] pc_out,
  output logic        bubble_out,
  output logic [7:0]  exc_out
);

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] pc_q;
  logic        bubble_q;

  assign mem_addr   = fetch_pc;
  assign mem_ren    = 1'b1;
  assign pc_out     = pc_q;
  assign bubble_out = bubble_q;

`ifdef FETCH_ALIGN_CHECK_EN
  logic [7:0] exc_q;
  logic       mis_q;
  assign exc_out = exc_q;

  // Misaligned target is remembered across REDIRECT, reported on exit
  always_ff @(posedge clk) begin
    if (rst) begin
      exc_q <= EXC_NONE;
      mis_q <= 1'b0;
    end else if (!halt && clk_en) begin
      if (flush) begin
        exc_q <= EXC_NONE;
        mis_q <= |redirect_pc[1:0];
      end else if (!stall) begin
        exc_q <= (state == REDIRECT && mis_q) ?
                 EXC_FETCH_MISALIGN : EXC_NONE;
        mis_q <= 1'b0;
      end
    end
  end
`else
  assign exc_out = EXC_NONE;
`endif

  // Fetch PC, decode-side slot registers and boot/redirect state
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT;
      fetch_pc <= word_align(RESET_PC);
      pc_q     <= RESET_PC;
      bubble_q <= 1'b1;
    end else if (!halt && clk_en) begin
      if (flush) begin
        state    <= REDIRECT;
        fetch_pc <= word_align(redirect_pc);
        pc_q     <= fetch_pc;
        bubble_q <= 1'b1;
      end else if (!stall) begin
        unique case (state)
          BOOT, RUN, REDIRECT: begin
            state    <= RUN;
            fetch_pc <= fetch_pc + PC_STEP;
            pc_q     <= fetch_pc;
            bubble_q <= 1'b0;
          end
          default: begin
            state    <= BOOT;
            bubble_q <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/fetch.md
Name: fetch

Overview:
- Instruction-fetch stage; the producer side of the decode stage's instruction interface.
- Owns the fetch PC and issues word addresses to the synchronous instruction memory (1-cycle read latency).
- Presents pc_out, bubble_out and exc_out to decode aligned with the memory's data-out word.
- Honours the pipeline's halt/clk_en/stall/flush contract and inserts bubbles on boot and redirect.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- PC_STEP, 32'd4, byte increment per sequential fetch.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- clk_en  in  1  global clock enable; when 0 no state changes
- halt  in  1  freeze: when 1 no state changes (wins over everything but rst)
- stall  in  1  downstream stall; hold fetch address and outputs
- flush  in  1  redirect request from later stage
- redirect_pc  in  32  target address, valid when flush=1
- mem_addr  out  32  instruction memory read address (equals fetch_pc register)
- mem_ren  out  1  read enable
- pc_out  out  32  PC of the word arriving on memory data-out this cycle
- bubble_out  out  1  1 = word on memory data-out is not a valid instruction
- exc_out  out  8  fetch exception code for this slot, 0 = none

Behaviour:
- Priority each posedge: rst > halt > !clk_en > flush > stall > advance.
- Reset values:
  - fetch_pc=RESET_PC; state=BOOT.
  - pc_out=RESET_PC; bubble_out=1; exc_out=0.
  - mem_ren=1; mem_addr tracks fetch_pc.
- halt=1 or clk_en=0: all registers hold, including state.
- States:
  - BOOT: exactly one cycle after reset. bubble_out stays 1 (memory data not yet valid). At the next enabled edge: pc_out<=fetch_pc, bubble_out<=0, fetch_pc+=PC_STEP; go RUN.
  - RUN, advance: pc_out<=fetch_pc, bubble_out<=0, fetch_pc<=fetch_pc+PC_STEP (mod 2^32; wraps 32'hFFFF_FFFC -> 0).
  - RUN, stall=1: fetch_pc, pc_out, bubble_out, exc_out hold; mem_ren stays 1 so the same word is re-presented.
  - RUN, flush=1 (regardless of stall): fetch_pc<=redirect_pc; pc_out<=old fetch_pc; bubble_out<=1 (wrong-path word); exc_out<=0; go REDIRECT.
  - REDIRECT: exactly one cycle. Next enabled edge behaves as RUN advance (or stall/flush per priority); go RUN (a flush re-enters REDIRECT).
  - flush in BOOT: treated as RUN flush.
- Latency: flush at edge N -> redirect_pc word valid (bubble_out=0, pc_out=redirect_pc) after edge N+1. Exactly one bubble per flush.
- Back-to-back flushes: each cycle's redirect_pc wins; bubble_out stays 1 until one cycle after the last flush.
- redirect_pc[1:0] and RESET_PC[1:0] are forced to 0 before loading fetch_pc.
- Reset asserted mid-stall or mid-redirect: pure reset values next cycle; pending redirect is discarded.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined: on flush with redirect_pc[1:0]!=0, the REDIRECT-exit slot (pc_out = aligned redirect_pc) carries exc_out=8'h82 and bubble_out=0, so the exception flows down the pipe. exc_out holds under stall and clears on the next advance.
- Undefined: low bits silently zeroed; exc_out constant 0.

Decomposition:
- Shared constants header (fetch_defs): state encodings (BOOT=2'd0, RUN=2'd1, REDIRECT=2'd2), EXC_FETCH_MISALIGN=8'h82, default RESET_PC.
- No sub-module; next-PC mux and state register stay inline.

Test Plan:
- Reset, 4 free-running cycles -> bubble_out=1 one cycle, then pc_out=0x0,0x4,0x8 with bubble_out=0; mem_addr leads pc_out by one cycle.
- Stall for 3 cycles at pc_out=0x8 -> pc_out=0x8, mem_addr=0xC held; release -> pc_out=0xC next.
- Flush redirect_pc=0x100 while pc_out=0x8 -> next cycle bubble_out=1, pc_out=0xC; following cycle pc_out=0x100, bubble_out=0; then 0x104.
- Flush+stall same edge, redirect_pc=0x200; then flush again next cycle to 0x300 -> both slots bubble, then pc_out=0x300; no 0x200 slot ever valid.
- halt=1 for 2 cycles during REDIRECT, and clk_en=0 for 2 cycles -> all outputs frozen; resumes with identical sequence.
- With FETCH_ALIGN_CHECK_EN, flush to 0x102 -> pc_out=0x100, exc_out=8'h82, bubble_out=0; next pc_out=0x104, exc_out=0. Without the macro -> same PCs, exc_out=0.
